// File: rtl/op_queue_if.sv
// Fetch-to-core op handshake bundle for op_queue.
// The queue takes the slave side; the fetch/core environment drives the master side.
interface op_queue_if;
  logic       in_valid;
  logic [2:0] in_opcode;
  logic [2:0] in_src_a;
  logic [2:0] in_src_b;
  logic [2:0] in_dest;
  logic [7:0] in_imm;

  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_opcode;
  logic [2:0] out_src_a;
  logic [2:0] out_src_b;
  logic [2:0] out_dest;
  logic [7:0] out_imm;

  modport master (
    output in_valid, in_opcode, in_src_a, in_src_b, in_dest, in_imm, out_ready,
    input  out_valid, out_opcode, out_src_a, out_src_b, out_dest, out_imm
  );

  modport slave (
    input  in_valid, in_opcode, in_src_a, in_src_b, in_dest, in_imm, out_ready,
    output out_valid, out_opcode, out_src_a, out_src_b, out_dest, out_imm
  );
endinterface

// File: rtl/op_queue.sv
// Decoded-op FIFO between fetch and execute with sticky overflow detection.
// Optional same-cycle bypass of an empty queue when OP_QUEUE_BYPASS_EN is defined.
module op_queue #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  op_queue_if.slave        bus,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [19:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [19:0]       in_word;
  logic [19:0]       head;
  logic [19:0]       out_word;
  logic              empty;
  logic              bypass;
  logic              consume;
  logic              pop;
  logic              push;
  logic              drop;

  assign in_word = {bus.in_opcode, bus.in_src_a, bus.in_src_b, bus.in_dest, bus.in_imm};
  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

`ifdef OP_QUEUE_BYPASS_EN
  assign bypass = empty && bus.in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed op taken by the core this cycle never touches storage.
  assign consume = bypass && bus.out_ready;
  assign pop     = !empty && bus.out_ready && !flush;
  assign push    = bus.in_valid && !flush && !consume && (!full || pop);
  assign drop    = bus.in_valid && !flush && full && !pop;

  assign bus.out_valid = !empty || bypass;
  assign out_word      = bypass ? in_word : head;
  assign {bus.out_opcode, bus.out_src_a, bus.out_src_b, bus.out_dest, bus.out_imm} = out_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is zeroed only by reset; flush leaves stale contents behind the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_word;
    end
  end

endmodule

// File: tb/tb_op_queue.sv
// Directed scoreboard bench for op_queue: expected ops queued on push, compared on pop.
// Covers the bypass path as well when OP_QUEUE_BYPASS_EN is defined.
module tb_op_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overflow;

  op_queue_if bus ();

  op_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          pass_cnt;
  int          total_cnt;
  logic [19:0] exp_q [$];
  logic        exp_ovf;

  function automatic logic [19:0] mk(input logic [7:0] imm);
    return {imm[2:0], imm[5:3], ~imm[2:0], imm[7:5], imm};
  endfunction

  function automatic logic [19:0] head_word();
    return {bus.out_opcode, bus.out_src_a, bus.out_src_b, bus.out_dest, bus.out_imm};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of stimulus; outputs checked mid-cycle before the edge and #1 after it.
  task automatic apply_stimulus(input logic v, input logic [19:0] op, input logic rdy, input logic fl);
    logic byp;
    logic pop;
    logic push;
    int   sz;
    @(negedge clk);
    bus.in_valid = v;
    {bus.in_opcode, bus.in_src_a, bus.in_src_b, bus.in_dest, bus.in_imm} = op;
    bus.out_ready = rdy;
    flush = fl;
    #1;
    sz  = exp_q.size();
    byp = 1'b0;
`ifdef OP_QUEUE_BYPASS_EN
    byp = (sz == 0) && v && !fl;
`endif
    check_output("out_valid", 32'(bus.out_valid), 32'(sz != 0 || byp));
    pop = (sz != 0) && rdy && !fl;
    if (pop) begin
      check_output("head", 32'(head_word()), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end else if (byp) begin
      check_output("bypass_head", 32'(head_word()), 32'(op));
    end
    push = v && !fl && !(byp && rdy) && (sz < DEPTH || pop);
    if (v && !fl && !(byp && rdy) && !push) exp_ovf = 1'b1;
    if (fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end
    if (push) exp_q.push_back(op);
    @(posedge clk);
    #1;
    check_output("count", 32'(count), 32'(exp_q.size()));
    check_output("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check_output("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic check_reset_outputs();
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    check_output("rst_fields", 32'(head_word()), 32'd0);
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    exp_ovf       = 1'b0;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    {bus.in_opcode, bus.in_src_a, bus.in_src_b, bus.in_dest, bus.in_imm} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single op round trip, then an empty cycle with out_ready high.
    apply_stimulus(1'b1, {3'd2, 3'd1, 3'd2, 3'd3, 8'hA5}, 1'b0, 1'b0);
    apply_stimulus(1'b0, 20'h0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 20'h0, 1'b1, 1'b0);

    // Fill to full, drain in order.
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, mk(8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 20'h0, 1'b1, 1'b0);

    // Overflow on full; sticky through drain until flush.
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, mk(8'(i)), 1'b0, 1'b0);
    apply_stimulus(1'b1, mk(8'h05), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 20'h0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 20'h0, 1'b0, 1'b1);

    // Push and pop together at full, then run the pointers around several times.
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, mk(8'(i)), 1'b0, 1'b0);
    apply_stimulus(1'b1, mk(8'h06), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, mk(8'(8'h10 + i)), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 20'h0, 1'b1, 1'b0);

    // Flush beats a simultaneous push; queue restarts cleanly.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, mk(8'(8'h40 + i)), 1'b0, 1'b0);
    apply_stimulus(1'b1, mk(8'h55), 1'b0, 1'b1);
    apply_stimulus(1'b1, mk(8'h77), 1'b0, 1'b0);
    apply_stimulus(1'b0, 20'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a pop cycle.
    apply_stimulus(1'b1, mk(8'h31), 1'b0, 1'b0);
    apply_stimulus(1'b1, mk(8'h32), 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b0;

    // Empty queue with an op arriving and the core ready.
    apply_stimulus(1'b1, mk(8'hB1), 1'b1, 1'b0);
    apply_stimulus(1'b1, mk(8'hB2), 1'b0, 1'b0);
    apply_stimulus(1'b0, 20'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/op_queue.md
Name: op_queue

Overview:
- Decoded-instruction FIFO between the instruction fetch stage and the CPU execute core.
- Captures each op the fetch stage emits: opcode, src_a, src_b, dest and imm, framed by op_valid.
- Replays ops to the core under a valid/ready handshake, so the core may stall without losing instructions.
- Fetch has no backpressure, so overflow is detected and flagged (sticky), never silently hidden.

Parameters:
DEPTH, 4, number of op entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of count output (derived localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  op_valid from fetch; push when high
in_opcode  input  3  opcode from fetch
in_src_a  input  3  source A register index
in_src_b  input  3  source B register index
in_dest  input  3  destination register index
in_imm  input  8  immediate
flush  input  1  synchronous discard of all queued ops
out_valid  output  1  head entry present
out_ready  input  1  core accepts head this cycle
out_opcode  output  3  head opcode
out_src_a  output  3  head src_a
out_src_b  output  3  head src_b
out_dest  output  3  head dest
out_imm  output  8  head imm
count  output  CNT_W  occupied entries, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky: a push was dropped

Behaviour:
- Storage:
  - DEPTH x 20-bit entries {opcode, src_a, src_b, dest, imm}.
  - Write pointer and read pointer are ADDR_W=$clog2(DEPTH) bits; both wrap modulo DEPTH.
  - Occupancy is held in a separate count register.
- Reset (rst low, async): pointers, count, overflow cleared and all entries zeroed, so out_valid=0, full=0, all out_* fields = 0. Reset mid-transfer discards everything.
- Push: in_valid=1 and (not full, or pop in the same cycle) -> entry written at wr_ptr, wr_ptr+1.
- Pop: out_valid & out_ready -> rd_ptr+1.
- count: +1 on push-only, -1 on pop-only, unchanged on push+pop.
- Full with simultaneous pop and push: both happen; count stays DEPTH, no overflow.
- Full, in_valid=1, no pop: op dropped, overflow set to 1. overflow is cleared only by reset or flush.
- Empty, out_ready=1: no pop, pointers unchanged. out_ready is ignored while out_valid=0.
- Output timing:
  - out_valid = (count != 0).
  - out_* fields are read combinationally from entry[rd_ptr] (registered storage, no combinational path from in_* ports).
  - Push-to-out_valid latency is 1 cycle.
- Field values when out_valid=0: out_* are don't-care, but stable (last head slot contents).
- flush=1 (sync):
  - Effect: pointers, count and overflow cleared; storage not cleared.
  - Simultaneous push: flush wins, the op is dropped and overflow is not set.
  - Simultaneous pop: flush wins.
- Ordering: strict FIFO; no reordering and no duplication.

Optional Feature:
- Macro OP_QUEUE_BYPASS_EN.
- Defined:
  - Condition: count==0, in_valid=1, flush=0.
  - out_valid=1 that same cycle, with out_* driven combinationally from in_*.
  - If out_ready=1: the op is consumed directly, nothing is written and count stays 0.
  - If out_ready=0: the op is pushed normally, count=1 next cycle.
- Undefined: no bypass; minimum latency 1 cycle as above.

Test Plan:
1. Reset, then push op {opcode=3'd2, src_a=1, src_b=2, dest=3, imm=8'hA5} with out_ready=0 -> next cycle out_valid=1, fields match, count=1; assert out_ready -> out_valid=0 and count=0 after one cycle.
2. Push imm=8'h01,02,03,04 back-to-back with out_ready=0 (DEPTH=4) -> full=1, count=4; drain with out_ready=1 -> imm order 01,02,03,04, overflow=0.
3. At full, push imm=8'h05 with out_ready=0 -> dropped, overflow=1, count=4; drain yields 01..04 only; overflow stays 1 until flush.
4. At full, push imm=8'h06 with out_ready=1 the same cycle -> head popped, 06 enqueued, count=4, overflow=0; pointer wrap verified over 10 further push/pop pairs.
5. count=3, assert flush together with in_valid -> next cycle count=0, out_valid=0, overflow=0; a subsequent push imm=8'h77 appears at head.
6. Pull rst low with count=2 mid-pop -> out_valid=0, count=0 and all out_* =0 immediately; with OP_QUEUE_BYPASS_EN, empty queue, in_valid=1 and out_ready=1 -> same-cycle out_valid=1 and count stays 0.
